oam_dma: RTL and testbench

OAM DMA engine for the Game Boy core: a memory-bus initiator that copies `LEN` bytes from `{src, 8'h00}` in the system address space into object attribute memory. A CPU write to the DMA register starts it. It drives the same `addr`/`re` read protocol the cartridge and work-RAM responders serve, and writes OAM through a dedicated port. It sits beside the CPU in the bus arbiter; `active` tells the arbiter to grant the bus to the DMA and block CPU accesses outside HRAM.

---
 rtl/oam_dma.sv | 179 +++++++++++++++++
 tb/tb_oam_dma.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// oam_dma: copies LEN bytes from system page {src,8'h00} into OAM, started by a CPU write to REG_ADDR.
// Optional macro OAM_DMA_START_DELAY_EN adds one idle byte slot (DELAY) before the copy begins.
`default_nettype none

module oam_dma #(
  parameter int unsigned LEN             = 160,
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter logic [15:0] REG_ADDR        = 16'hFF46
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] bus_addr,
  output logic        bus_re,
  input  logic [7:0]  bus_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        active
);

  localparam int unsigned     PH_W     = $clog2(CYCLES_PER_BYTE);
  localparam logic [PH_W-1:0] PH_ZERO  = '0;
  localparam logic [PH_W-1:0] PH_READ  = PH_W'(0);
  localparam logic [PH_W-1:0] PH_CAPT  = PH_W'(1);
  localparam logic [PH_W-1:0] PH_WRITE = PH_W'(2);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0]      IDX_LAST = 8'(LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_XFER  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      src_q, src_d;
  logic [7:0]      idx_q, idx_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [7:0]      data_q, data_d;

  logic [15:0]     bus_addr_q, bus_addr_d;
  logic            bus_re_q, bus_re_d;
  logic [7:0]      oam_addr_q, oam_addr_d;
  logic [7:0]      oam_wdata_q, oam_wdata_d;
  logic            oam_we_q, oam_we_d;
  logic            active_q, active_d;

  logic            reg_wr;
  logic            reg_rd;

  // E0-FF fold onto the C0-DF echo region.
  function automatic logic [7:0] fold_page(input logic [7:0] s);
    return (s >= 8'hE0) ? (s - 8'h20) : s;
  endfunction

  assign reg_wr = cpu_we && (cpu_addr == REG_ADDR);
  assign reg_rd = cpu_re && (cpu_addr == REG_ADDR);

  assign cpu_rdata = reg_rd ? src_q : 8'hzz;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    idx_d       = idx_q;
    ph_d        = ph_q;
    data_d      = data_q;
    bus_re_d    = 1'b0;
    bus_addr_d  = bus_addr_q;
    oam_we_d    = 1'b0;
    oam_addr_d  = oam_addr_q;
    oam_wdata_d = oam_wdata_q;

    if (reg_wr) begin
      // A register write always wins over whatever phase action was due.
      src_d = cpu_wdata;
      idx_d = 8'd0;
      ph_d  = PH_ZERO;
`ifdef OAM_DMA_START_DELAY_EN
      state_d = S_DELAY;
`else
      state_d = S_XFER;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          ph_d  = PH_ZERO;
          idx_d = 8'd0;
        end
`ifdef OAM_DMA_START_DELAY_EN
        S_DELAY: begin
          if (ph_q == PH_LAST) begin
            ph_d    = PH_ZERO;
            state_d = S_XFER;
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
`endif
        S_XFER: begin
          if (ph_q == PH_CAPT) begin
            data_d = bus_rdata;
          end
          if (ph_q == PH_LAST) begin
            ph_d  = PH_ZERO;
            idx_d = idx_q + 8'd1;
            if (idx_q == IDX_LAST) begin
              idx_d   = 8'd0;
              state_d = S_IDLE;
            end
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          ph_d    = PH_ZERO;
          idx_d   = 8'd0;
        end
      endcase
    end

    // Outputs are registered: decode them from the state being entered.
    active_d = (state_d != S_IDLE);
    if (state_d == S_XFER) begin
      if (ph_d == PH_READ) begin
        bus_re_d   = 1'b1;
        bus_addr_d = {fold_page(src_d), idx_d};
      end
      if (ph_d == PH_WRITE) begin
        oam_we_d    = 1'b1;
        oam_addr_d  = idx_d;
        oam_wdata_d = data_d;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      src_q       <= 8'hFF;
      idx_q       <= 8'd0;
      ph_q        <= PH_ZERO;
      data_q      <= 8'd0;
      bus_addr_q  <= 16'h0000;
      bus_re_q    <= 1'b0;
      oam_addr_q  <= 8'd0;
      oam_wdata_q <= 8'd0;
      oam_we_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      idx_q       <= idx_d;
      ph_q        <= ph_d;
      data_q      <= data_d;
      bus_addr_q  <= bus_addr_d;
      bus_re_q    <= bus_re_d;
      oam_addr_q  <= oam_addr_d;
      oam_wdata_q <= oam_wdata_d;
      oam_we_q    <= oam_we_d;
      active_q    <= active_d;
    end
  end

  assign bus_addr  = bus_addr_q;
  assign bus_re    = bus_re_q;
  assign oam_addr  = oam_addr_q;
  assign oam_wdata = oam_wdata_q;
  assign oam_we    = oam_we_q;
  assign active    = active_q;

endmodule

`default_nettype wire

// File: tb/tb_oam_dma.sv
// tb_oam_dma: scoreboard bench for oam_dma; a work-RAM style responder returns addr[7:0]^8'h5A.
`default_nettype none

module tb_oam_dma;

  localparam int          LEN = 160;
  localparam int          CPB = 4;
  localparam logic [15:0] REG = 16'hFF46;
`ifdef OAM_DMA_START_DELAY_EN
  localparam int D = CPB;
`else
  localparam int D = 0;
`endif
  localparam int ACT_CYC = D + LEN * CPB;

  logic        Clk;
  logic        Reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic        bus_re;
  logic [7:0]  bus_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        active;

  oam_dma #(
    .LEN             (LEN),
    .CYCLES_PER_BYTE (CPB),
    .REG_ADDR        (REG)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_rdata (cpu_rdata),
    .bus_addr  (bus_addr),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .oam_addr  (oam_addr),
    .oam_wdata (oam_wdata),
    .oam_we    (oam_we),
    .active    (active)
  );

  typedef struct {
    logic [15:0] addr;
    int          cyc;
  } rd_t;

  typedef struct {
    logic [7:0] idx;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  rd_t rd_q[$];
  wr_t wr_q[$];

  int          chk_cnt   = 0;
  int          pass_cnt  = 0;
  int          cyc       = 0;
  int          act_start = 0;
  int          act_end   = 0;
  int          wr_cnt    = 0;
  int          act_cnt   = 0;
  bit          mon_en    = 0;
  logic [15:0] last_ba   = 16'h0000;
  logic [7:0]  rsp_q     = 8'hEE;
  logic        exp_act;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Registered responder: data valid the clock after re, junk otherwise.
  always @(posedge Clk) rsp_q <= bus_re ? (bus_addr[7:0] ^ 8'h5A) : 8'hEE;
  assign bus_rdata = rsp_q;

  // Scoreboard consumer: every bus read and OAM write must match the head of its queue.
  always @(negedge Clk) begin
    if (mon_en) begin
      exp_act = Reset && (cyc > act_start) && (cyc <= act_end);
      chk_cnt++;
      if (active !== exp_act) $display("FAIL active cyc=%0d got=%b exp=%b", cyc, active, exp_act);
      else pass_cnt++;
      if (active === 1'b1) act_cnt++;

      if (!Reset) begin
        last_ba = 16'h0000;
      end else if (bus_re === 1'b1) begin
        last_ba = bus_addr;
        chk_cnt++;
        if (rd_q.size() == 0) begin
          $display("FAIL unexpected_read cyc=%0d got_addr=%h exp=none", cyc, bus_addr);
        end else begin
          rd_t r;
          r = rd_q.pop_front();
          if (bus_addr !== r.addr || cyc != r.cyc)
            $display("FAIL read cyc=%0d got_addr=%h exp_addr=%h exp_cyc=%0d", cyc, bus_addr, r.addr, r.cyc);
          else pass_cnt++;
        end
      end else begin
        chk_cnt++;
        if (bus_addr !== last_ba) $display("FAIL bus_addr_hold got=%h exp=%h", bus_addr, last_ba);
        else pass_cnt++;
      end

      if (oam_we === 1'b1) begin
        wr_cnt++;
        chk_cnt++;
        if (wr_q.size() == 0) begin
          $display("FAIL unexpected_oam_we cyc=%0d got_addr=%h exp=none", cyc, oam_addr);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          if (oam_addr !== w.idx || oam_wdata !== w.data || cyc != w.cyc)
            $display("FAIL oam_write cyc=%0d got=%h/%h exp=%h/%h exp_cyc=%0d",
                     cyc, oam_addr, oam_wdata, w.idx, w.data, w.cyc);
          else pass_cnt++;
        end
      end
    end
  end

  // Call just after a falling edge; the write lands on the next rising edge.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] page;
    rd_t r;
    wr_t w;
    #1;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = 1'b1;
    if (a == REG) begin
      rd_q.delete();
      wr_q.delete();
      page = (d >= 8'hE0) ? (d - 8'h20) : d;
      for (int i = 0; i < LEN; i++) begin
        r.addr = {page, 8'(i)};
        r.cyc  = cyc + D + CPB * i + 1;
        rd_q.push_back(r);
        w.idx  = 8'(i);
        w.data = 8'(i) ^ 8'h5A;
        w.cyc  = cyc + D + CPB * i + 3;
        wr_q.push_back(w);
      end
      act_start = cyc;
      act_end   = cyc + ACT_CYC;
    end
    @(negedge Clk);
    #1;
    cpu_we = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge Clk);
      if (active === 1'b0 && cyc > act_end) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 Reset = 1'b0;
    repeat (3) @(negedge Clk);
    chk_cnt++; if (bus_re !== 1'b0) $display("FAIL rst_bus_re got=%b exp=0", bus_re); else pass_cnt++;
    chk_cnt++; if (bus_addr !== 16'h0000) $display("FAIL rst_bus_addr got=%h exp=0000", bus_addr); else pass_cnt++;
    chk_cnt++; if (oam_we !== 1'b0) $display("FAIL rst_oam_we got=%b exp=0", oam_we); else pass_cnt++;
    chk_cnt++; if (oam_addr !== 8'h00) $display("FAIL rst_oam_addr got=%h exp=00", oam_addr); else pass_cnt++;
    chk_cnt++; if (oam_wdata !== 8'h00) $display("FAIL rst_oam_wdata got=%h exp=00", oam_wdata); else pass_cnt++;
    chk_cnt++; if (active !== 1'b0) $display("FAIL rst_active got=%b exp=0", active); else pass_cnt++;
    #1 Reset = 1'b1;
    mon_en = 1'b1;
    cpu_addr = REG;
    cpu_re   = 1'b1;
    #1;
    chk_cnt++; if (cpu_rdata !== 8'hFF) $display("FAIL rst_src got=%h exp=ff", cpu_rdata); else pass_cnt++;
    cpu_re = 1'b0;
  endtask

  task automatic test_reg_access();
    bit ok;
    @(negedge Clk);
    cpu_write(REG, 8'h12);
    cpu_addr = REG;
    cpu_re   = 1'b1;
    #1;
    chk_cnt++; if (cpu_rdata !== 8'h12) $display("FAIL reg_read got=%h exp=12", cpu_rdata); else pass_cnt++;
    cpu_addr = 16'hFF47;
    #1;
    chk_cnt++; if (cpu_rdata === 8'h12) $display("FAIL reg_unselected got=%h exp=zz", cpu_rdata); else pass_cnt++;
    cpu_re = 1'b0;
    wait_idle(ok);
    chk_cnt++; if (!ok) $display("FAIL reg_xfer_idle got=busy exp=idle"); else pass_cnt++;
    chk_cnt++; if (rd_q.size() + wr_q.size() != 0) $display("FAIL reg_xfer_left got=%0d exp=0", rd_q.size() + wr_q.size()); else pass_cnt++;
  endtask

  task automatic test_no_start();
    @(negedge Clk);
    wr_cnt = 0;
    cpu_write(16'hFF45, 8'h80);
    repeat (20) @(negedge Clk);
    chk_cnt++; if (active !== 1'b0 || wr_cnt != 0) $display("FAIL no_start got=%b/%0d exp=0/0", active, wr_cnt); else pass_cnt++;
    #1 cpu_addr = REG;
    cpu_re = 1'b1;
    #1;
    chk_cnt++; if (cpu_rdata !== 8'h12) $display("FAIL no_start_src got=%h exp=12", cpu_rdata); else pass_cnt++;
    cpu_re = 1'b0;
  endtask

  task automatic test_copy(input logic [7:0] s);
    bit ok;
    @(negedge Clk);
    #1;
    wr_cnt  = 0;
    act_cnt = 0;
    @(negedge Clk);
    cpu_write(REG, s);
    wait_idle(ok);
    chk_cnt++; if (!ok) $display("FAIL copy_%h_idle got=busy exp=idle", s); else pass_cnt++;
    chk_cnt++; if (wr_cnt != LEN) $display("FAIL copy_%h_writes got=%0d exp=%0d", s, wr_cnt, LEN); else pass_cnt++;
    chk_cnt++; if (act_cnt != ACT_CYC) $display("FAIL copy_%h_active got=%0d exp=%0d", s, act_cnt, ACT_CYC); else pass_cnt++;
    chk_cnt++; if (rd_q.size() + wr_q.size() != 0) $display("FAIL copy_%h_left got=%0d exp=0", s, rd_q.size() + wr_q.size()); else pass_cnt++;
  endtask

  task automatic test_restart();
    bit ok;
    bit seen;
    @(negedge Clk);
    #1 wr_cnt = 0;
    @(negedge Clk);
    cpu_write(REG, 8'hC0);
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge Clk);
      if (oam_we === 1'b1 && oam_addr == 8'd50) seen = 1'b1;
    end
    chk_cnt++; if (!seen) $display("FAIL restart_byte50 got=absent exp=present"); else pass_cnt++;
    cpu_write(REG, 8'hC1);
    wait_idle(ok);
    chk_cnt++; if (!ok) $display("FAIL restart_idle got=busy exp=idle"); else pass_cnt++;
    chk_cnt++; if (wr_cnt != 51 + LEN) $display("FAIL restart_writes got=%0d exp=%0d", wr_cnt, 51 + LEN); else pass_cnt++;
    chk_cnt++; if (rd_q.size() + wr_q.size() != 0) $display("FAIL restart_left got=%0d exp=0", rd_q.size() + wr_q.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge Clk);
    #1 wr_cnt = 0;
    @(negedge Clk);
    cpu_write(REG, 8'hC0);
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge Clk);
      if (bus_re === 1'b1 && bus_addr[7:0] == 8'd80) seen = 1'b1;
    end
    chk_cnt++; if (!seen) $display("FAIL mid_byte80 got=absent exp=present"); else pass_cnt++;
    #1;
    rd_q.delete();
    wr_q.delete();
    act_end = 0;
    Reset = 1'b0;
    #1;
    chk_cnt++; if (bus_re !== 1'b0 || bus_addr !== 16'h0000) $display("FAIL mid_bus got=%b/%h exp=0/0000", bus_re, bus_addr); else pass_cnt++;
    chk_cnt++; if (oam_we !== 1'b0 || oam_addr !== 8'h00 || oam_wdata !== 8'h00)
      $display("FAIL mid_oam got=%b/%h/%h exp=0/00/00", oam_we, oam_addr, oam_wdata); else pass_cnt++;
    chk_cnt++; if (active !== 1'b0) $display("FAIL mid_active got=%b exp=0", active); else pass_cnt++;
    repeat (4) @(negedge Clk);
    #1 Reset = 1'b1;
    repeat (40) @(negedge Clk);
    chk_cnt++; if (wr_cnt != 80) $display("FAIL mid_writes got=%0d exp=80", wr_cnt); else pass_cnt++;
    #1 cpu_addr = REG;
    cpu_re = 1'b1;
    #1;
    chk_cnt++; if (cpu_rdata !== 8'hFF) $display("FAIL mid_src got=%h exp=ff", cpu_rdata); else pass_cnt++;
    cpu_re = 1'b0;
  endtask

  initial begin
    Reset     = 1'b1;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_we    = 1'b0;
    cpu_re    = 1'b0;
    test_reset();
    test_reg_access();
    test_no_start();
    test_copy(8'hC0);
    test_copy(8'hE3);
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
